// File: rtl/bcd_76entry_if.sv
// Keypad, adder and display signals of the BCD operand-entry controller.
// The ovf signal exists only when BCD76_OVF_DETECT_EN is defined.
interface bcd_76entry_if #(
  parameter int DIGITS = 19
);
  logic                  key_valid;
  logic [4:0]            key_code;
  logic                  key_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [4*DIGITS-1:0]   s;
  logic [4*DIGITS-1:0]   disp;
  logic [4:0]            digit_count;
  logic [1:0]            state;
  logic                  full;
`ifdef BCD76_OVF_DETECT_EN
  logic                  ovf;

  modport master (
    output key_valid, key_code, s,
    input  key_ready, a, b, disp, digit_count, state, full, ovf
  );

  modport slave (
    input  key_valid, key_code, s,
    output key_ready, a, b, disp, digit_count, state, full, ovf
  );
`else
  modport master (
    output key_valid, key_code, s,
    input  key_ready, a, b, disp, digit_count, state, full
  );

  modport slave (
    input  key_valid, key_code, s,
    output key_ready, a, b, disp, digit_count, state, full
  );
`endif
endinterface

// File: rtl/bcd_76entry.sv
// Keypad operand entry and sum capture for the packed-BCD adder; a key takes effect one cycle after
// acceptance, key_ready drops for SETTLE_CYCLES while the sum settles. Optional ovf: BCD76_OVF_DETECT_EN.
module bcd_76entry #(
  parameter int DIGITS        = 19,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_76entry_if.slave     bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [4:0] DMAX    = 5'(DIGITS);
  localparam logic [4:0] K_PLUS  = 5'd10;
  localparam logic [4:0] K_EQ    = 5'd11;
  localparam logic [4:0] K_CLEAR = 5'd12;
  localparam logic [4:0] K_BACK  = 5'd13;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  state_t          st_q, st_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [CW-1:0]   settle_q, settle_d;
`ifdef BCD76_OVF_DETECT_EN
  logic            ovf_q, ovf_d;
`endif

  logic            acc;
  logic            is_digit;
  logic [3:0]      dig;
  logic [W-1:0]    cur;
  logic [W-1:0]    op_d;

  assign acc      = bus.key_valid && (st_q != CAPTURE);
  assign is_digit = bus.key_code < 5'd10;
  assign dig      = bus.key_code[3:0];
  assign cur      = (st_q == ENTER_B) ? b_q : a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
`ifdef BCD76_OVF_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      st_q     <= st_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
`ifdef BCD76_OVF_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    st_d     = st_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    op_d     = cur;
`ifdef BCD76_OVF_DETECT_EN
    ovf_d    = ovf_q;
`endif

    if (st_q == CAPTURE) begin
      // Sample on the edge the counter would reach zero, so ready is low exactly SETTLE_CYCLES cycles.
      if (settle_q <= CW'(1)) begin
        res_d    = bus.s;
        settle_d = '0;
        st_d     = SHOW;
`ifdef BCD76_OVF_DETECT_EN
        ovf_d    = bus.s < a_q;
`endif
      end else begin
        settle_d = settle_q - CW'(1);
      end
    end else if (acc) begin
      if (bus.key_code == K_CLEAR) begin
        a_d   = '0;
        b_d   = '0;
        res_d = '0;
        cnt_d = '0;
        st_d  = ENTER_A;
`ifdef BCD76_OVF_DETECT_EN
        ovf_d = 1'b0;
`endif
      end else if (st_q == SHOW) begin
        if (is_digit) begin
          a_d   = W'(dig);
          b_d   = '0;
          cnt_d = {4'd0, dig != 4'd0};
          st_d  = ENTER_A;
`ifdef BCD76_OVF_DETECT_EN
          ovf_d = 1'b0;
`endif
        end else if (bus.key_code == K_PLUS) begin
          a_d   = res_q;
          b_d   = '0;
          cnt_d = '0;
          st_d  = ENTER_B;
        end
      end else begin
        if (is_digit) begin
          // Leading zeros are swallowed; a digit beyond capacity is accepted but dropped.
          if (!(cnt_q == 5'd0 && dig == 4'd0) && cnt_q < DMAX) begin
            op_d  = {cur[W-5:0], dig};
            cnt_d = cnt_q + 5'd1;
          end
        end else if (bus.key_code == K_BACK) begin
          if (cnt_q != 5'd0) begin
            op_d  = cur >> 4;
            cnt_d = cnt_q - 5'd1;
          end
        end

        if (st_q == ENTER_B) b_d = op_d;
        else                 a_d = op_d;

        if (bus.key_code == K_PLUS && st_q == ENTER_A) begin
          b_d   = '0;
          cnt_d = '0;
          st_d  = ENTER_B;
        end else if (bus.key_code == K_EQ && st_q == ENTER_B) begin
          settle_d = CW'(SETTLE_CYCLES);
          st_d     = CAPTURE;
        end
      end
    end
  end

  assign bus.key_ready   = (st_q != CAPTURE);
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.digit_count = cnt_q;
  assign bus.state       = st_q;
  assign bus.full        = (cnt_q == DMAX);
  assign bus.disp        = (st_q == ENTER_A) ? a_q :
                           (st_q == SHOW)    ? res_q : b_q;
`ifdef BCD76_OVF_DETECT_EN
  assign bus.ovf         = ovf_q;
`endif
endmodule

// File: tb/tb_bcd_76entry.sv
// Directed vector bench for bcd_76entry with a digit-serial BCD adder model on s.
module tb_bcd_76entry;
  localparam int DIGITS = 19;
  localparam int W      = 4 * DIGITS;
  localparam int SETTLE = 2;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bcd_76entry_if #(.DIGITS(DIGITS)) bus();

  bcd_76entry #(.DIGITS(DIGITS), .SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] bcd_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    int c, d;
    r = '0;
    c = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
      c = (d > 9) ? 1 : 0;
      if (d > 9) d = d - 10;
      r[4*i +: 4] = 4'(d);
    end
    return r;
  endfunction

  assign bus.s = bcd_add(bus.a, bus.b);

  typedef struct {
    logic [4:0]   code;
    logic [1:0]   st;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] disp;
    logic [4:0]   cnt;
    logic         full;
  } vec_t;

  vec_t tbl [0:27];
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] ea;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      press(tbl[i].code);
      chk($sformatf("vec%0d state", i), W'(bus.state), W'(tbl[i].st));
      chk($sformatf("vec%0d a", i), bus.a, tbl[i].a);
      chk($sformatf("vec%0d b", i), bus.b, tbl[i].b);
      chk($sformatf("vec%0d disp", i), bus.disp, tbl[i].disp);
      chk($sformatf("vec%0d count", i), W'(bus.digit_count), W'(tbl[i].cnt));
      chk($sformatf("vec%0d full", i), W'(bus.full), W'(tbl[i].full));
    end
  endtask

  task automatic do_equals(input bit hold, input logic [W-1:0] exp_res, input logic [W-1:0] exp_b);
    int low;
    low = 0;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd11;
    @(posedge clk);
    #1;
    if (hold) bus.key_code = 5'd1;
    else      bus.key_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.key_ready) break;
      low++;
      chk("capture b held", bus.b, exp_b);
      chk("capture state", W'(bus.state), W'(2));
    end
    bus.key_valid = 1'b0;
    chk("ready low cycles", W'(low), W'(SETTLE));
    chk("show state", W'(bus.state), W'(3));
    chk("result disp", bus.disp, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'd1,  2'd0, 76'h12 >> 4, 76'h0, 76'h1, 5'd1, 1'b0};
    tbl[1]  = '{5'd2,  2'd0, 76'h12, 76'h0,  76'h12, 5'd2, 1'b0};
    tbl[2]  = '{5'd10, 2'd1, 76'h12, 76'h0,  76'h0,  5'd0, 1'b0};
    tbl[3]  = '{5'd3,  2'd1, 76'h12, 76'h3,  76'h3,  5'd1, 1'b0};
    tbl[4]  = '{5'd4,  2'd1, 76'h12, 76'h34, 76'h34, 5'd2, 1'b0};
    tbl[5]  = '{5'd10, 2'd1, 76'h12, 76'h34, 76'h34, 5'd2, 1'b0};
    tbl[6]  = '{5'd13, 2'd1, 76'h12, 76'h3,  76'h3,  5'd1, 1'b0};
    tbl[7]  = '{5'd4,  2'd1, 76'h12, 76'h34, 76'h34, 5'd2, 1'b0};
    tbl[8]  = '{5'd20, 2'd1, 76'h12, 76'h34, 76'h34, 5'd2, 1'b0};
    tbl[9]  = '{5'd10, 2'd1, 76'h46, 76'h0,  76'h0,  5'd0, 1'b0};
    tbl[10] = '{5'd5,  2'd1, 76'h46, 76'h5,  76'h5,  5'd1, 1'b0};
    tbl[11] = '{5'd13, 2'd3, 76'h46, 76'h5,  76'h51, 5'd1, 1'b0};
    tbl[12] = '{5'd11, 2'd3, 76'h46, 76'h5,  76'h51, 5'd1, 1'b0};
    tbl[13] = '{5'd8,  2'd0, 76'h8,  76'h0,  76'h8,  5'd1, 1'b0};
    tbl[14] = '{5'd11, 2'd0, 76'h8,  76'h0,  76'h8,  5'd1, 1'b0};
    tbl[15] = '{5'd0,  2'd0, 76'h80, 76'h0,  76'h80, 5'd2, 1'b0};
    tbl[16] = '{5'd12, 2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[17] = '{5'd0,  2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[18] = '{5'd0,  2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[19] = '{5'd7,  2'd0, 76'h7,  76'h0,  76'h7,  5'd1, 1'b0};
    tbl[20] = '{5'd13, 2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[21] = '{5'd13, 2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[22] = '{5'd10, 2'd1, ALL9,   76'h0,  76'h0,  5'd0, 1'b0};
    tbl[23] = '{5'd1,  2'd1, ALL9,   76'h1,  76'h1,  5'd1, 1'b0};
    tbl[24] = '{5'd12, 2'd0, 76'h0,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[25] = '{5'd5,  2'd0, 76'h5,  76'h0,  76'h5,  5'd1, 1'b0};
    tbl[26] = '{5'd10, 2'd1, 76'h5,  76'h0,  76'h0,  5'd0, 1'b0};
    tbl[27] = '{5'd6,  2'd1, 76'h5,  76'h6,  76'h6,  5'd1, 1'b0};

    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset state", W'(bus.state), W'(0));
    chk("reset a", bus.a, '0);
    chk("reset b", bus.b, '0);
    chk("reset disp", bus.disp, '0);
    chk("reset count", W'(bus.digit_count), W'(0));
    chk("reset full", W'(bus.full), W'(0));
    chk("reset ready", W'(bus.key_ready), W'(1));
`ifdef BCD76_OVF_DETECT_EN
    chk("reset ovf", W'(bus.ovf), W'(0));
`endif
    rst_n = 1'b1;

    // 12 + 34 = 46
    run_range(0, 8);
    do_equals(1'b0, 76'h46, 76'h34);
    chk("first sum a", bus.a, 76'h12);
    chk("first sum b", bus.b, 76'h34);

    // chained 46 + 5 with a key held during capture
    run_range(9, 10);
    do_equals(1'b1, 76'h51, 76'h5);
    chk("chain a", bus.a, 76'h46);
    run_range(11, 21);

    // 20 nines: the last one is accepted but dropped
    ea = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) chk("ready before 20th nine", W'(bus.key_ready), W'(1));
      press(5'd9);
      if (k <= 19) ea = {ea[W-5:0], 4'h9};
      chk($sformatf("nine%0d a", k), bus.a, ea);
      chk($sformatf("nine%0d count", k), W'(bus.digit_count), W'((k <= 19) ? k : 19));
      chk($sformatf("nine%0d full", k), W'(bus.full), W'(k >= 19));
    end
    chk("all nines a", bus.a, ALL9);

    // 19 nines + 1 wraps to zero
    run_range(22, 23);
    do_equals(1'b0, 76'h0, 76'h1);
`ifdef BCD76_OVF_DETECT_EN
    chk("ovf set on wrap", W'(bus.ovf), W'(1));
`endif
    run_range(24, 24);
`ifdef BCD76_OVF_DETECT_EN
    chk("ovf cleared", W'(bus.ovf), W'(0));
`endif

    // reset in the middle of capture
    run_range(25, 27);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'd11;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk("mid capture state", W'(bus.state), W'(2));
    rst_n = 1'b0;
    #1;
    chk("async reset state", W'(bus.state), W'(0));
    chk("async reset a", bus.a, '0);
    chk("async reset b", bus.b, '0);
    chk("async reset disp", bus.disp, '0);
    chk("async reset count", W'(bus.digit_count), W'(0));
    chk("async reset ready", W'(bus.key_ready), W'(1));
    chk("async reset full", W'(bus.full), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no late capture state", W'(bus.state), W'(0));
    chk("no late capture disp", bus.disp, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_76entry.md
Name: bcd_76entry

Overview:
- Operand-entry and result-capture controller for the 19-digit (76-bit packed BCD) adder.
- Accepts keypad codes one at a time over a valid/ready handshake and builds operand A, then operand B, by shifting digits in at the least-significant digit.
- Drives A and B onto the adder, waits a fixed settle time, then registers the adder sum for display.
- Sits directly upstream of the adder (feeds a/b) and also consumes its s output.

Parameters:
- DIGITS, 19, number of BCD digits per operand; register width is 4*DIGITS.
- SETTLE_CYCLES, 2, cycles the adder inputs are held stable before s is sampled; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  key_code is valid this cycle.
- key_code  input  5  0-9 digit, 10 plus, 11 equals, 12 clear, 13 backspace, 14-31 no-op.
- key_ready  output  1  block can accept a key this cycle.
- a  output  4*DIGITS  operand A to adder.
- b  output  4*DIGITS  operand B to adder.
- s  input  4*DIGITS  sum from adder.
- disp  output  4*DIGITS  value to show (A, B or result).
- digit_count  output  5  significant digits entered in the current operand, 0..DIGITS.
- state  output  2  0 ENTER_A, 1 ENTER_B, 2 CAPTURE, 3 SHOW.
- full  output  1  high while digit_count == DIGITS.

Behaviour:
- One clock domain, one clock and one reset.
- Reset is asynchronous, active-low, and fixed that way.
- Reset values: a = b = result = 0, digit_count = 0, state = ENTER_A, key_ready = 1, full = 0.
- Reset asserted mid-CAPTURE aborts the capture; no result is latched.
- Handshake:
  - A key is accepted on a rising edge where key_valid && key_ready.
  - Its effect is visible on the registers one cycle later.
  - key_code is ignored when key_ready = 0.
- key_ready = 0 only in CAPTURE; 1 in every other state.
- Digit key in ENTER_A or ENTER_B (applies to the current operand):
  - count == 0 and digit == 0: no change. Leading zeros are not counted.
  - count < DIGITS: operand <= {operand[4*DIGITS-5:0], digit}, count + 1.
  - count == DIGITS: key is accepted and discarded; operand unchanged.
- Backspace in ENTER_A or ENTER_B: operand <= operand >> 4, count - 1 if count > 0. At count 0 it is a no-op.
- Plus:
  - In ENTER_A: go to ENTER_B, b <= 0, count <= 0.
  - In ENTER_B: ignored.
  - In SHOW: a <= result, b <= 0, count <= 0, go to ENTER_B (chained addition).
- Equals:
  - In ENTER_B: go to CAPTURE and load the settle counter with SETTLE_CYCLES.
  - In ENTER_A and SHOW: ignored.
- CAPTURE:
  - a and b are held.
  - The counter decrements each cycle.
  - On the edge where it reaches 0: result <= s, go to SHOW.
  - key_ready is low for exactly SETTLE_CYCLES cycles.
- Digit key in SHOW: a <= {0..., digit}, b <= 0, count = (digit != 0), go to ENTER_A. Backspace in SHOW is ignored.
- Clear in any state except CAPTURE: a, b, result, count <= 0, go to ENTER_A.
- Codes 14-31 are accepted with no effect.
- disp = a in ENTER_A, b in ENTER_B and CAPTURE, result in SHOW.
- Arithmetic overflow beyond 19 digits wraps silently; only the low 76 bits come back from the adder.
- All digits held are valid BCD (0-9). Key codes 0-9 are the only digit source.

Optional Feature:
- Macro: BCD76_OVF_DETECT_EN.
- When defined:
  - Adds output ovf (1 bit, reset 0).
  - At the result-capture edge, ovf <= (s < a) under unsigned binary compare, which preserves order for packed BCD.
  - ovf is cleared by clear, by a digit key in SHOW, and by reset.
  - In SHOW, disp is unchanged.
- When undefined: no ovf port, no compare logic; wrap-around is invisible.

Test Plan:
- Reset, then keys 1,2,+,3,4,= -> after SETTLE_CYCLES low cycles on key_ready: state 3, disp = 0x...0046, a = 0x12, b = 0x34.
- Keys 0,0,7 in ENTER_A -> a = 0x7, digit_count = 1. Then backspace twice -> a = 0, digit_count = 0.
- 20 digit-9 keys in ENTER_A -> a = all 9s (76 bits), full = 1, digit_count = 19; the 20th key is accepted and discarded.
- After result 0x46 shown, keys +,5,= -> a = 0x46, b = 0x5, result 0x51. A digit key 8 then gives state 0, a = 0x8.
- key_valid held high with code 1 during CAPTURE -> no acceptance, b unchanged. Assert rst_n = 0 mid-CAPTURE -> all outputs at reset values immediately.
- With BCD76_OVF_DETECT_EN: a = 19 nines, b = 0x1, = -> result = 0, ovf = 1. Clear -> ovf = 0.
